// File: rtl/sap_control_sequencer.sv
// Fetch/execute sequencer for the 8-bit SAP CPU: one-hot T1..T6 ring plus opcode decode into the bus control word.
// Optional macro SEQ_EARLY_END_EN: OUT/NOP retire after T4 and LDA after T5.
module sap_control_sequencer #(
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned CTRL_W = 12
) (
    input  logic              clock,
    input  logic              input_clear,
    input  logic              input_run,
    input  logic [OPC_W-1:0]  input_opcode,
    output logic [CTRL_W-1:0] output_control,
    output logic [5:0]        output_t_state,
    output logic              output_halted
);

    typedef enum logic [5:0] {
        S_HALT = 6'b000000,
        S_T1   = 6'b000001,
        S_T2   = 6'b000010,
        S_T3   = 6'b000100,
        S_T4   = 6'b001000,
        S_T5   = 6'b010000,
        S_T6   = 6'b100000
    } t_state_e;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'b0000);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'b1110);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'b1111);

    // Control word bit map: Cp Ep Lm Er Li Ei La Ea Su Eu Lb Lo
    localparam logic [CTRL_W-1:0] C_EP_LM    = CTRL_W'(12'h600);
    localparam logic [CTRL_W-1:0] C_CP       = CTRL_W'(12'h800);
    localparam logic [CTRL_W-1:0] C_ER_LI    = CTRL_W'(12'h180);
    localparam logic [CTRL_W-1:0] C_EI_LM    = CTRL_W'(12'h240);
    localparam logic [CTRL_W-1:0] C_EA_LO    = CTRL_W'(12'h011);
    localparam logic [CTRL_W-1:0] C_ER_LA    = CTRL_W'(12'h120);
    localparam logic [CTRL_W-1:0] C_ER_LB    = CTRL_W'(12'h102);
    localparam logic [CTRL_W-1:0] C_EU_LA    = CTRL_W'(12'h024);
    localparam logic [CTRL_W-1:0] C_SU_EU_LA = CTRL_W'(12'h02C);

    t_state_e state;
    logic     halted;
    logic     is_lda;
    logic     is_alu;
    logic     is_mem;
    logic     is_out;
    logic     is_hlt;

    assign is_lda = (input_opcode == OP_LDA);
    assign is_alu = (input_opcode == OP_ADD) || (input_opcode == OP_SUB);
    assign is_mem = is_lda || is_alu;
    assign is_out = (input_opcode == OP_OUT);
    assign is_hlt = (input_opcode == OP_HLT);

    // Ring sequencer and sticky halt; clear overrides everything including halt.
    always_ff @(posedge clock) begin
        if (input_clear) begin
            state  <= S_T1;
            halted <= 1'b0;
        end else if (input_run && !halted) begin
            case (state)
                S_T1: state <= S_T2;
                S_T2: state <= S_T3;
                S_T3: state <= S_T4;
                S_T4: begin
                    if (is_hlt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
`ifdef SEQ_EARLY_END_EN
                    end else if (!is_mem) begin
                        state <= S_T1;
`endif
                    end else begin
                        state <= S_T5;
                    end
                end
`ifdef SEQ_EARLY_END_EN
                S_T5:    state <= is_lda ? S_T1 : S_T6;
`else
                S_T5:    state <= S_T6;
`endif
                S_T6:    state <= S_T1;
                default: state <= S_T1;
            endcase
        end
    end

    // Decode; T1..T3 deliberately ignore the opcode so IR settling cannot glitch fetch.
    always_comb begin
        output_control = '0;
        if (input_run && !halted) begin
            case (state)
                S_T1: output_control = C_EP_LM;
                S_T2: output_control = C_CP;
                S_T3: output_control = C_ER_LI;
                S_T4: begin
                    if (is_mem)      output_control = C_EI_LM;
                    else if (is_out) output_control = C_EA_LO;
                end
                S_T5: begin
                    if (is_lda)      output_control = C_ER_LA;
                    else if (is_alu) output_control = C_ER_LB;
                end
                S_T6: begin
                    if (input_opcode == OP_ADD)      output_control = C_EU_LA;
                    else if (input_opcode == OP_SUB) output_control = C_SU_EU_LA;
                end
                default: output_control = '0;
            endcase
        end
    end

    assign output_t_state = state;
    assign output_halted  = halted;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: directed scenarios plus randomized run against an instruction-level model.
module tb_sap_control_sequencer;

    logic        clock = 1'b0;
    logic        input_clear = 1'b0;
    logic        input_run = 1'b0;
    logic [3:0]  input_opcode = 4'b0000;
    logic [11:0] output_control;
    logic [5:0]  output_t_state;
    logic        output_halted;

    int vectors = 0;
    int miscompares = 0;

    // Model: position within the current instruction (1..6) and halt flag.
    int   m_step = 1;
    logic m_halted = 1'b0;

    sap_control_sequencer dut (
        .clock          (clock),
        .input_clear    (input_clear),
        .input_run      (input_run),
        .input_opcode   (input_opcode),
        .output_control (output_control),
        .output_t_state (output_t_state),
        .output_halted  (output_halted)
    );

    always #5 clock = ~clock;

    function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
        if (op == 4'b0000) return 5;
        if (op == 4'b0001 || op == 4'b0010) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op,
                                             input logic run, input logic halted);
        logic mem;
        mem = (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010);
        if (!run || halted) return 12'h000;
        case (step)
            1: return 12'h600;
            2: return 12'h800;
            3: return 12'h180;
            4: return mem ? 12'h240 : (op == 4'b1110) ? 12'h011 : 12'h000;
            5: return (op == 4'b0000) ? 12'h120 : mem ? 12'h102 : 12'h000;
            6: return (op == 4'b0001) ? 12'h024 : (op == 4'b0010) ? 12'h02C : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [5:0] exp_state();
        if (m_halted) return 6'b000000;
        return 6'(1 << (m_step - 1));
    endfunction

    function automatic int drivers(input logic [11:0] c);
        return int'(c[10]) + int'(c[8]) + int'(c[6]) + int'(c[4]) + int'(c[2]);
    endfunction

    task automatic apply(input logic clr, input logic run, input logic [3:0] op);
        input_clear  = clr;
        input_run    = run;
        input_opcode = op;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        if (input_clear) begin
            m_step   = 1;
            m_halted = 1'b0;
        end else if (input_run && !m_halted) begin
            if (m_step == 4 && input_opcode == 4'b1111) m_halted = 1'b1;
            else if (m_step >= instr_len(input_opcode)) m_step = 1;
            else m_step = m_step + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 4'b0001);
        tick();
        apply(1'b0, 1'b1, 4'b0001);
        vectors++;
        if (output_t_state !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_t_state got %h exp 01", output_t_state);
        end
        vectors++;
        if (output_halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_halted got %b exp 0", output_halted);
        end
        vectors++;
        if (output_control !== 12'h600) begin
            miscompares++;
            $display("FAIL reset_control got %h exp 600", output_control);
        end
    endtask

    task automatic test_add_sequence();
        logic [5:0]  st [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        logic [11:0] cw [7] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024, 12'h600};
        apply(1'b1, 1'b1, 4'b0001);
        tick();
        apply(1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (output_t_state !== st[i] || output_control !== cw[i]) begin
                miscompares++;
                $display("FAIL add_seq step %0d got state %h ctrl %h exp state %h ctrl %h",
                         i, output_t_state, output_control, st[i], cw[i]);
            end
            tick();
        end
    endtask

    task automatic test_sub_sequence();
        logic [5:0]  st [4] = '{6'h08, 6'h10, 6'h20, 6'h01};
        logic [11:0] cw [4] = '{12'h240, 12'h102, 12'h02C, 12'h600};
        apply(1'b1, 1'b1, 4'b0010);
        tick();
        apply(1'b0, 1'b1, 4'b0111);
        tick();
        apply(1'b0, 1'b1, 4'b1111);
        tick();
        // Opcode changes during fetch must not disturb T3
        apply(1'b0, 1'b1, 4'b1110);
        vectors++;
        if (output_control !== 12'h180) begin
            miscompares++;
            $display("FAIL sub_fetch_opcode_change got %h exp 180", output_control);
        end
        tick();
        apply(1'b0, 1'b1, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (output_t_state !== st[i] || output_control !== cw[i]) begin
                miscompares++;
                $display("FAIL sub_seq step %0d got state %h ctrl %h exp state %h ctrl %h",
                         i, output_t_state, output_control, st[i], cw[i]);
            end
            tick();
        end
    endtask

    task automatic test_run_pause();
        apply(1'b1, 1'b1, 4'b0001);
        tick();
        apply(1'b0, 1'b1, 4'b0001);
        tick();
        tick();
        apply(1'b0, 1'b0, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (output_t_state !== 6'h04 || output_control !== 12'h000) begin
                miscompares++;
                $display("FAIL pause cycle %0d got state %h ctrl %h exp state 04 ctrl 000",
                         i, output_t_state, output_control);
            end
            tick();
        end
        apply(1'b0, 1'b1, 4'b0001);
        vectors++;
        if (output_t_state !== 6'h04 || output_control !== 12'h180) begin
            miscompares++;
            $display("FAIL resume_t3 got state %h ctrl %h exp state 04 ctrl 180",
                     output_t_state, output_control);
        end
        tick();
        vectors++;
        if (output_t_state !== 6'h08 || output_control !== 12'h240) begin
            miscompares++;
            $display("FAIL resume_t4 got state %h ctrl %h exp state 08 ctrl 240",
                     output_t_state, output_control);
        end
    endtask

    task automatic test_halt();
        apply(1'b1, 1'b1, 4'b1111);
        tick();
        apply(1'b0, 1'b1, 4'b1111);
        tick();
        tick();
        tick();
        vectors++;
        if (output_t_state !== 6'h08 || output_control !== 12'h000 || output_halted !== 1'b0) begin
            miscompares++;
            $display("FAIL hlt_t4 got state %h ctrl %h halted %b exp state 08 ctrl 000 halted 0",
                     output_t_state, output_control, output_halted);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 4'($urandom_range(0, 15)));
            vectors++;
            if (output_halted !== 1'b1 || output_t_state !== 6'h00 || output_control !== 12'h000) begin
                miscompares++;
                $display("FAIL halted cycle %0d got halted %b state %h ctrl %h exp 1 00 000",
                         i, output_halted, output_t_state, output_control);
            end
            tick();
        end
        apply(1'b1, 1'b1, 4'b1111);
        tick();
        apply(1'b0, 1'b1, 4'b0000);
        vectors++;
        if (output_halted !== 1'b0 || output_t_state !== 6'h01) begin
            miscompares++;
            $display("FAIL hlt_clear got halted %b state %h exp 0 01", output_halted, output_t_state);
        end
    endtask

    task automatic test_clear_midflight();
        apply(1'b1, 1'b1, 4'b0000);
        tick();
        apply(1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (output_t_state !== 6'h10 || output_control !== 12'h120) begin
            miscompares++;
            $display("FAIL lda_t5 got state %h ctrl %h exp state 10 ctrl 120",
                     output_t_state, output_control);
        end
        apply(1'b1, 1'b1, 4'b0000);
        tick();
        apply(1'b0, 1'b1, 4'b0000);
        vectors++;
        if (output_t_state !== 6'h01 || output_control !== 12'h600) begin
            miscompares++;
            $display("FAIL clear_midflight got state %h ctrl %h exp state 01 ctrl 600",
                     output_t_state, output_control);
        end
    endtask

    task automatic test_out_early_end();
        apply(1'b1, 1'b1, 4'b1110);
        tick();
        apply(1'b0, 1'b1, 4'b1110);
        tick();
        tick();
        tick();
        vectors++;
        if (output_t_state !== 6'h08 || output_control !== 12'h011) begin
            miscompares++;
            $display("FAIL out_t4 got state %h ctrl %h exp state 08 ctrl 011",
                     output_t_state, output_control);
        end
        tick();
`ifndef SEQ_EARLY_END_EN
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (output_t_state !== 6'(6'h10 << i) || output_control !== 12'h000) begin
                miscompares++;
                $display("FAIL out_tail %0d got state %h ctrl %h exp state %h ctrl 000",
                         i, output_t_state, output_control, 6'(6'h10 << i));
            end
            tick();
        end
`endif
        vectors++;
        if (output_t_state !== 6'h01 || output_control !== 12'h600) begin
            miscompares++;
            $display("FAIL out_wrap got state %h ctrl %h exp state 01 ctrl 600",
                     output_t_state, output_control);
        end
    endtask

    task automatic test_random();
        logic [11:0] ec;
        apply(1'b1, 1'b1, 4'b0000);
        tick();
        for (int i = 0; i < 600; i++) begin
            apply(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 7) != 0),
                  4'($urandom_range(0, 15)));
            ec = exp_ctrl(m_step, input_opcode, input_run, m_halted);
            vectors++;
            if (output_t_state !== exp_state() || output_halted !== m_halted || output_control !== ec) begin
                miscompares++;
                $display("FAIL random cyc %0d got state %h halted %b ctrl %h exp state %h halted %b ctrl %h",
                         i, output_t_state, output_halted, output_control, exp_state(), m_halted, ec);
            end
            vectors++;
            if (drivers(output_control) > 1) begin
                miscompares++;
                $display("FAIL bus_drivers cyc %0d got %0d drivers in ctrl %h exp at most 1",
                         i, drivers(output_control), output_control);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add_sequence();
        test_sub_sequence();
        test_run_pause();
        test_halt();
        test_clear_midflight();
        test_out_early_end();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
